// File: rtl/grey_pkg.sv
// Shared widths and types for the Bayer-to-greyscale path.
package grey_pkg;

  localparam int PIX_W = 12;
  localparam int SUM_W = PIX_W + 2;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [SUM_W-1:0] sum_t;

endpackage

// File: rtl/grey_sum4.sv
// Combinational widening adder: four pixels into one sum that cannot overflow.
module grey_sum4
  import grey_pkg::*;
(
  input  pix_t i_a,
  input  pix_t i_b,
  input  pix_t i_c,
  input  pix_t i_d,
  output sum_t o_sum
);

  sum_t w_ab;
  sum_t w_cd;

  // Zero-extend before adding so the carries land in the two extra bits.
  assign w_ab  = sum_t'(i_a) + sum_t'(i_b);
  assign w_cd  = sum_t'(i_c) + sum_t'(i_d);
  assign o_sum = w_ab + w_cd;

endmodule

// File: rtl/grey_scale.sv
// Averages a 2x2 Bayer quad (this column and the previous one, two rows) into grey.
// Build option GREY_ROUND_EN selects round-half-up instead of truncation.
module grey_scale
  import grey_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  pix_t data_in_1,
  input  pix_t data_in_2,
  output pix_t data_out
);

  pix_t r_prev_1;
  pix_t r_prev_2;
  sum_t w_sum;

  function automatic pix_t quad_avg(input sum_t s);
    sum_t t;
`ifdef GREY_ROUND_EN
    // Worst case 4*4095+2 still fits in SUM_W bits.
    t = s + sum_t'(2);
`else
    t = s;
`endif
    return t[SUM_W-1:2];
  endfunction

  grey_sum4 u_sum4 (
    .i_a   (data_in_1),
    .i_b   (data_in_2),
    .i_c   (r_prev_1),
    .i_d   (r_prev_2),
    .o_sum (w_sum)
  );

  // Stage boundary: column history and registered grey output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_1 <= '0;
      r_prev_2 <= '0;
      data_out <= '0;
    end else begin
      r_prev_1 <= data_in_1;
      r_prev_2 <= data_in_2;
      data_out <= quad_avg(w_sum);
    end
  end

endmodule

// File: tb/tb_grey_scale.sv
// Scoreboard bench for grey_scale; honours GREY_ROUND_EN in its reference model.
module tb_grey_scale;
  import grey_pkg::*;

  logic clk;
  logic rst;
  pix_t data_in_1;
  pix_t data_in_2;
  pix_t data_out;

  int n_chk  = 0;
  int n_pass = 0;
  int m_p1   = 0;
  int m_p2   = 0;
  int exp_q[$];

  grey_scale dut (
    .clk       (clk),
    .rst       (rst),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Mean of the current and previous column pair, from plain integer arithmetic.
  function automatic int model(input int d1, input int d2);
    int s;
    s = d1 + d2 + m_p1 + m_p2;
`ifdef GREY_ROUND_EN
    return (s + 2) / 4;
`else
    return s / 4;
`endif
  endfunction

  function automatic int pick(input int trunc_v, input int round_v);
`ifdef GREY_ROUND_EN
    return round_v;
`else
    return trunc_v;
`endif
  endfunction

  // Drive one sample pair, push its expected result, and move past the edge.
  task automatic step(input int d1, input int d2);
    data_in_1 = pix_t'(d1);
    data_in_2 = pix_t'(d2);
    exp_q.push_back(model(d1, d2));
    m_p1 = d1;
    m_p2 = d2;
    @(posedge clk);
    #2;
  endtask

  task automatic enter_reset();
    rst = 1'b0;
    m_p1 = 0;
    m_p2 = 0;
    exp_q.delete();
  endtask

  // Monitor: every edge out of reset yields one result to compare.
  always @(posedge clk) begin
    #1;
    if (rst && exp_q.size() > 0) check("scoreboard", int'(data_out), exp_q.pop_front());
  end

  initial begin
    rst       = 1'b0;
    data_in_1 = 12'd1234;
    data_in_2 = 12'd3333;
    enter_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", int'(data_out), 0);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;

    step(10, 20);
    check("ramp0", int'(data_out), pick(7, 8));
    step(20, 40);
    check("ramp1", int'(data_out), pick(22, 23));
    step(30, 60);
    check("ramp2", int'(data_out), pick(37, 38));

    // Asynchronous reset between edges must clear the output immediately.
    #1;
    enter_reset();
    #1;
    check("async_reset", int'(data_out), 0);
    data_in_1 = 12'd500;
    data_in_2 = 12'd700;
    @(posedge clk);
    #1;
    check("reset_held", int'(data_out), 0);
    #1;
    rst = 1'b1;
    step(8, 8);
    check("restart", int'(data_out), 4);

    step(4095, 4095);
    step(4095, 4095);
    check("saturate", int'(data_out), 4095);

    step(4090, 100);
    step(4, 100);
    check("wrap", int'(data_out), pick(1073, 1074));

    step(0, 0);
    step(0, 0);
    check("zero", int'(data_out), 0);

    for (int i = 0; i < 300; i++) begin
      int a;
      int b;
      a = $urandom_range(0, 4095);
      b = $urandom_range(0, 4095);
      if (i % 37 == 5) a = 4095;
      if (i % 41 == 7) b = 0;
      step(a, b);
    end

    for (int i = 0; i < 3; i++) begin
      enter_reset();
      @(posedge clk);
      #2;
      check("rand_reset", int'(data_out), 0);
      rst = 1'b1;
      for (int j = 0; j < 20; j++) step($urandom_range(0, 4095), $urandom_range(0, 4095));
    end

    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
